// File: rtl/mul_responder_pkg.sv
// mul_resp_pkg: shared types and default sizing for the multiply request/response path
package mul_resp_pkg;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MUL_DATA_W    = 64;
    localparam int MUL_STEP_BITS = 1;
    localparam int MUL_TAG_W     = 4;
    localparam int N_STEPS       = MUL_DATA_W / MUL_STEP_BITS;
    localparam int CNT_W         = cnt_width(N_STEPS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [MUL_DATA_W-1:0] a;
        logic [MUL_DATA_W-1:0] b;
        logic [MUL_TAG_W-1:0]  tag;
    } mul_req_t;

endpackage

// File: rtl/mul_responder_if.sv
// mul_responder_if: multiply request/response valid-ready bundle
interface mul_responder_if
    import mul_resp_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W,
    parameter int TAG_W  = MUL_TAG_W
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_lo;
    logic [DATA_W-1:0] rsp_hi;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag
    );
endinterface

// File: rtl/mul_responder_step_dp.sv
// mul_step_dp: one shift-add iteration consuming STEP_BITS multiplier bits
module mul_step_dp #(
    parameter int DATA_W    = 64,
    parameter int STEP_BITS = 1
) (
    input  logic [2*DATA_W-1:0] acc_in,
    input  logic [2*DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0]   b_in,
    output logic [2*DATA_W-1:0] acc_out,
    output logic [2*DATA_W-1:0] a_out,
    output logic [DATA_W-1:0]   b_out
);
    // Add the multiplicand shifted by each set multiplier bit, then advance both operands
    always_comb begin
        acc_out = acc_in;
        for (int i = 0; i < STEP_BITS; i++)
            acc_out = b_in[i] ? acc_out + (a_in << i) : acc_out;
        a_out = a_in << STEP_BITS;
        b_out = b_in >> STEP_BITS;
    end
endmodule

// File: rtl/mul_responder.sv
// mul_responder: fixed-latency iterative 64x64 unsigned multiplier behind valid/ready
module mul_responder
    import mul_resp_pkg::*;
#(
    parameter int DATA_W    = MUL_DATA_W,
    parameter int STEP_BITS = MUL_STEP_BITS,
    parameter int TAG_W     = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_responder_if.slave   bus,
    output logic             busy
);
    localparam int N  = DATA_W / STEP_BITS;
    localparam int CW = cnt_width(N);

    if (STEP_BITS < 1 || DATA_W % STEP_BITS != 0) begin : g_bad_step
        $error("mul_responder: STEP_BITS must divide DATA_W");
    end

    state_t              state;
    logic                req_ready;
    logic                rsp_valid;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] a_sh;
    logic [DATA_W-1:0]   b_sh;
    logic [TAG_W-1:0]    tag;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc_nx;
    logic [2*DATA_W-1:0] a_nx;
    logic [DATA_W-1:0]   b_nx;

    mul_step_dp #(.DATA_W(DATA_W), .STEP_BITS(STEP_BITS)) u_step (
        .acc_in (acc),
        .a_in   (a_sh),
        .b_in   (b_sh),
        .acc_out(acc_nx),
        .a_out  (a_nx),
        .b_out  (b_nx)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_lo    = acc[DATA_W-1:0];
    assign bus.rsp_hi    = acc[2*DATA_W-1:DATA_W];
    assign bus.rsp_tag   = tag;

    // Request capture, fixed-count shift-add iteration and response hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            tag       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && req_ready) begin
                    a_sh      <= {{DATA_W{1'b0}}, bus.req_a};
                    b_sh      <= bus.req_b;
                    tag       <= bus.req_tag;
                    acc       <= '0;
                    cnt       <= CW'(N - 1);
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= BUSY;
                end
                BUSY: begin
                    acc  <= acc_nx;
                    a_sh <= a_nx;
                    b_sh <= b_nx;
                    if (cnt == '0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: if (rsp_valid && bus.rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_responder.sv
// tb_mul_responder: randomized self-checking bench for mul_responder
module tb_mul_responder;
    import mul_resp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mul_responder_if bus ();

    mul_responder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] wa = {64'd0, a};
        logic [127:0] wb = {64'd0, b};
        return wa * wb;
    endfunction

    task automatic wait_accept();
        int w = 0;
        while (!bus.req_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input mul_req_t r, output int lat, output logic [127:0] prod,
                         output logic [3:0] tg, output bit one_wide);
        bus.req_a = r.a;
        bus.req_b = r.b;
        bus.req_tag = r.tag;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        wait_accept();
        bus.req_valid = 1'b0;
        bus.req_a = {$urandom, $urandom};
        bus.req_b = {$urandom, $urandom};
        bus.req_tag = 4'($urandom);
        wait_rsp(lat);
        prod = {bus.rsp_hi, bus.rsp_lo};
        tg = bus.rsp_tag;
        @(posedge clk); #1;
        one_wide = !bus.rsp_valid && bus.req_ready;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_tag = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.rsp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got valid=%b busy=%b exp 0 0", bus.rsp_valid, busy);
        end
        checks++;
        if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_tag} !== '0) begin
            failures++;
            $display("FAIL reset_data got hi=%h lo=%h tag=%h exp 0", bus.rsp_hi, bus.rsp_lo, bus.rsp_tag);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [127:0] p;
        logic [3:0] tg;
        bit ow;
        do_op('{a: 64'd3, b: 64'd5, tag: 4'd2}, lat, p, tg, ow);
        checks++;
        if (lat !== N_STEPS) begin failures++; $display("FAIL basic_lat got=%0d exp=%0d", lat, N_STEPS); end
        checks++;
        if (p !== 128'd15) begin failures++; $display("FAIL basic_prod got=%h exp=%h", p, 128'd15); end
        checks++;
        if (tg !== 4'd2) begin failures++; $display("FAIL basic_tag got=%0d exp=2", tg); end
        checks++;
        if (ow !== 1'b1) begin failures++; $display("FAIL basic_one_cycle got=%b exp=1", ow); end
    endtask

    task automatic test_corners();
        int lat;
        logic [127:0] p;
        logic [3:0] tg;
        bit ow;
        do_op('{a: '1, b: '1, tag: 4'd9}, lat, p, tg, ow);
        checks++;
        if (p !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
            failures++;
            $display("FAIL max_prod got=%h exp=%h", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        end
        checks++;
        if (lat !== N_STEPS) begin failures++; $display("FAIL max_lat got=%0d exp=%0d", lat, N_STEPS); end
        do_op('{a: 64'h1_0000_0000, b: 64'h1_0000_0000, tag: 4'd3}, lat, p, tg, ow);
        checks++;
        if (p !== {64'd1, 64'd0}) begin failures++; $display("FAIL pow32_prod got=%h exp=%h", p, {64'd1, 64'd0}); end
        do_op('{a: {$urandom, $urandom}, b: 64'd0, tag: 4'd4}, lat, p, tg, ow);
        checks++;
        if (p !== 128'd0 || lat !== N_STEPS) begin
            failures++;
            $display("FAIL zero_op got prod=%h lat=%0d exp prod=0 lat=%0d", p, lat, N_STEPS);
        end
    endtask

    task automatic test_random();
        mul_req_t r;
        int lat;
        logic [127:0] p;
        logic [3:0] tg;
        bit ow;
        for (int k = 0; k < 8; k++) begin
            r.a = {$urandom, $urandom};
            r.b = {$urandom, $urandom} >> $urandom_range(63, 0);
            r.tag = 4'($urandom);
            do_op(r, lat, p, tg, ow);
            checks++;
            if (p !== ref_mul(r.a, r.b)) begin
                failures++;
                $display("FAIL rand_prod a=%h b=%h got=%h exp=%h", r.a, r.b, p, ref_mul(r.a, r.b));
            end
            checks++;
            if (tg !== r.tag || lat !== N_STEPS) begin
                failures++;
                $display("FAIL rand_tag_lat got tag=%0d lat=%0d exp tag=%0d lat=%0d", tg, lat, r.tag, N_STEPS);
            end
        end
    endtask

    task automatic test_backpressure();
        mul_req_t r1, r2;
        int lat;
        logic [127:0] p;
        logic [3:0] tg;
        bit stable = 1'b1;
        r1 = '{a: {$urandom, $urandom}, b: {$urandom, $urandom}, tag: 4'd11};
        r2 = '{a: {$urandom, $urandom}, b: {$urandom, $urandom}, tag: 4'd12};
        bus.req_a = r1.a;
        bus.req_b = r1.b;
        bus.req_tag = r1.tag;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        wait_accept();
        bus.req_a = r2.a;
        bus.req_b = r2.b;
        bus.req_tag = r2.tag;
        wait_rsp(lat);
        p = {bus.rsp_hi, bus.rsp_lo};
        tg = bus.rsp_tag;
        checks++;
        if (p !== ref_mul(r1.a, r1.b) || tg !== r1.tag) begin
            failures++;
            $display("FAIL bp_first got=%h/%0d exp=%h/%0d", p, tg, ref_mul(r1.a, r1.b), r1.tag);
        end
        repeat (10) begin
            @(posedge clk); #1;
            if ({bus.rsp_hi, bus.rsp_lo} !== p || bus.rsp_tag !== tg || !bus.rsp_valid || bus.req_ready)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b exp=1", stable); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL bp_release got ready=%b valid=%b exp 1 0", bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if ({busy, bus.req_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_queued_accept got busy=%b ready=%b exp 1 0", busy, bus.req_ready);
        end
        wait_rsp(lat);
        checks++;
        if ({bus.rsp_hi, bus.rsp_lo} !== ref_mul(r2.a, r2.b) || bus.rsp_tag !== r2.tag || lat !== N_STEPS) begin
            failures++;
            $display("FAIL bp_second got=%h/%0d lat=%0d exp=%h/%0d", {bus.rsp_hi, bus.rsp_lo}, bus.rsp_tag, lat,
                     ref_mul(r2.a, r2.b), r2.tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, t0, t1;
        bus.req_a = 64'd7;
        bus.req_b = 64'd6;
        bus.req_tag = 4'd1;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        wait_accept();
        t0 = cyc;
        bus.req_a = 64'd0;
        bus.req_b = 64'd9;
        bus.req_tag = 4'd2;
        wait_rsp(lat);
        checks++;
        if ({bus.rsp_hi, bus.rsp_lo} !== ref_mul(64'd7, 64'd6) || bus.rsp_lo !== 64'd42 || bus.rsp_tag !== 4'd1) begin
            failures++;
            $display("FAIL b2b_first got=%h tag=%0d exp=42 tag=1", {bus.rsp_hi, bus.rsp_lo}, bus.rsp_tag);
        end
        checks++;
        if (lat !== N_STEPS) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, N_STEPS); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        t1 = cyc;
        bus.req_valid = 1'b0;
        checks++;
        if (t1 - t0 !== N_STEPS + 2) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=%0d", t1 - t0, N_STEPS + 2);
        end
        wait_rsp(lat);
        checks++;
        if ({bus.rsp_hi, bus.rsp_lo} !== 128'd0 || bus.rsp_tag !== 4'd2 || lat !== N_STEPS) begin
            failures++;
            $display("FAIL b2b_second got=%h tag=%0d lat=%0d exp=0 tag=2 lat=%0d",
                     {bus.rsp_hi, bus.rsp_lo}, bus.rsp_tag, lat, N_STEPS);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] p;
        logic [3:0] tg;
        bit ow;
        bit seen = 1'b0;
        bus.req_a = {$urandom, $urandom};
        bus.req_b = {$urandom, $urandom};
        bus.req_tag = 4'd7;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        wait_accept();
        bus.req_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, bus.rsp_valid} !== 2'b00 || {bus.rsp_hi, bus.rsp_lo, bus.rsp_tag} !== '0) begin
            failures++;
            $display("FAIL midrst_async got busy=%b valid=%b lo=%h exp all 0", busy, bus.rsp_valid, bus.rsp_lo);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (70) begin
            @(posedge clk); #1;
            seen |= bus.rsp_valid;
        end
        checks++;
        if (seen !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_discard got seen=%b ready=%b busy=%b exp 0 1 0", seen, bus.req_ready, busy);
        end
        do_op('{a: 64'd2, b: 64'd2, tag: 4'd5}, lat, p, tg, ow);
        checks++;
        if (p !== 128'd4 || tg !== 4'd5 || lat !== N_STEPS) begin
            failures++;
            $display("FAIL midrst_after got=%h tag=%0d lat=%0d exp=4 tag=5 lat=%0d", p, tg, lat, N_STEPS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
